// File: rtl/systolic_mm_engine.sv
// N x N output-stationary systolic multiplier C = A x B with skewed operand lanes.
// Ports: in_* operand stream (valid/ready, in_last), out_* row stream, busy; async active-low reset.
module systolic_mm_engine #(
  parameter int N      = 3,
  parameter int DW     = 8,
  parameter int ACC_W  = 24,
  parameter int SIGNED = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DW-1:0]        in_a,
  input  logic [N*DW-1:0]        in_b,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*ACC_W-1:0]     out_row,
  output logic [$clog2(N)-1:0]   out_row_idx,
  output logic                   out_last,
  output logic                   busy
);

  localparam int RW  = $clog2(N);
  localparam int CW  = $clog2(2*N);
  localparam int TRI = N*(N-1)/2;

  typedef enum logic [1:0] {
    IDLE, FEED, FLUSH, DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [RW-1:0] row;
  logic accept, flush_done, row_last;
  logic drain_hs, clear;

  logic [DW-1:0] a_lin  [N];
  logic [DW-1:0] b_lin  [N];
  logic [DW-1:0] a_lane [N];
  logic [DW-1:0] b_lane [N];
  logic [TRI*DW-1:0] a_sk, b_sk;

  logic [DW-1:0] a_reg [N][N-1];
  logic [DW-1:0] b_reg [N-1][N];
  logic [DW-1:0] a_in  [N][N];
  logic [DW-1:0] b_in  [N][N];
  logic [ACC_W-1:0] prod [N][N];
  logic [ACC_W-1:0] acc  [N][N];

  // lane i keeps its skew stages at [off(i), off(i)+i)
  function automatic int off(int i);
    return i*(i-1)/2;
  endfunction

  function automatic logic [ACC_W-1:0] mul_ext(
    logic [DW-1:0] a,
    logic [DW-1:0] b
  );
    logic sx;
    logic [2*DW-1:0] ax, bx, p;
    logic [ACC_W-1:0] r;
    sx = (SIGNED != 0);
    ax = {{DW{sx & a[DW-1]}}, a};
    bx = {{DW{sx & b[DW-1]}}, b};
    p  = ax * bx;
    r  = ACC_W'(p);
    if (sx && p[2*DW-1])
      r = r | ~(ACC_W'({2*DW{1'b1}}));
    return r;
  endfunction

  assign accept     = in_valid & in_ready;
  assign flush_done = (cnt == CW'(2*N-1));
  assign row_last   = (row == RW'(N-1));
  assign drain_hs   = (state == DRAIN) & out_ready;
  assign clear      = drain_hs & row_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (accept)
          state_nxt = in_last ? FLUSH : FEED;
      FEED:
        if (accept && in_last)
          state_nxt = FLUSH;
      FLUSH:
        if (flush_done)
          state_nxt = DRAIN;
      DRAIN:
        if (clear)
          state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = reset &
                  ((state == IDLE) | (state == FEED));
    out_valid   = (state == DRAIN);
    busy        = (state != IDLE);
    out_last    = out_valid & row_last;
    out_row_idx = row;
    out_row     = '0;
    if (state == DRAIN)
      for (int j = 0; j < N; j++)
        out_row[j*ACC_W +: ACC_W] = acc[row][j];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      row <= '0;
    end else begin
      if (state == FLUSH) cnt <= cnt + 1'b1;
      else                cnt <= '0;
      if (drain_hs)
        row <= row_last ? '0 : row + 1'b1;
    end
  end

  // idle or stalled cycles inject zeros so results are unaffected
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_lin[i] = accept ? in_a[i*DW +: DW] : '0;
      b_lin[i] = accept ? in_b[i*DW +: DW] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sk <= '0;
      b_sk <= '0;
    end else begin
      for (int i = 1; i < N; i++) begin
        a_sk[off(i)*DW +: DW] <= a_lin[i];
        b_sk[off(i)*DW +: DW] <= b_lin[i];
        for (int s = 1; s < i; s++) begin
          a_sk[(off(i)+s)*DW +: DW] <=
            a_sk[(off(i)+s-1)*DW +: DW];
          b_sk[(off(i)+s)*DW +: DW] <=
            b_sk[(off(i)+s-1)*DW +: DW];
        end
      end
    end
  end

  always_comb begin
    a_lane[0] = a_lin[0];
    b_lane[0] = b_lin[0];
    for (int i = 1; i < N; i++) begin
      a_lane[i] = a_sk[(off(i)+i-1)*DW +: DW];
      b_lane[i] = b_sk[(off(i)+i-1)*DW +: DW];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = a_lane[i];
      b_in[0][i] = b_lane[i];
    end
    for (int i = 0; i < N; i++)
      for (int j = 1; j < N; j++) begin
        a_in[i][j] = a_reg[i][j-1];
        b_in[j][i] = b_reg[j-1][i];
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        prod[i][j] = mul_ext(a_in[i][j], b_in[i][j]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          acc[i][j] <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N-1; j++) begin
          a_reg[i][j] <= '0;
          b_reg[j][i] <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          acc[i][j] <= clear ? '0 : acc[i][j] + prod[i][j];
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N-1; j++) begin
          a_reg[i][j] <= a_in[i][j];
          b_reg[j][i] <= b_in[j][i];
        end
    end
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench: signed 24-bit and unsigned 16-bit engines driven in lockstep.
// Covers latency, bubbles, output stall, sign handling, wrap and mid-job reset.
module tb_systolic_mm_engine;

  logic clk = 0;
  logic reset = 0;
  logic in_valid = 0;
  logic in_last = 0;
  logic out_ready = 1;
  logic [23:0] in_a = '0;
  logic [23:0] in_b = '0;

  logic in_ready_s, out_valid_s, out_last_s, busy_s;
  logic [71:0] out_row_s;
  logic [1:0] idx_s;
  logic in_ready_w, out_valid_w, out_last_w, busy_w;
  logic [47:0] out_row_w;
  logic [1:0] idx_w;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_s [9];
  logic [15:0] exp_w [9];

  always #5 clk = ~clk;

  systolic_mm_engine #(
    .N(3), .DW(8), .ACC_W(24), .SIGNED(1)
  ) dut_s (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_row(out_row_s), .out_row_idx(idx_s),
    .out_last(out_last_s), .busy(busy_s)
  );

  systolic_mm_engine #(
    .N(3), .DW(8), .ACC_W(16), .SIGNED(0)
  ) dut_w (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_w),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .out_row(out_row_w), .out_row_idx(idx_w),
    .out_last(out_last_w), .busy(busy_w)
  );

  task automatic chk(string tag, logic [127:0] obs,
                     logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic beat(logic [7:0] a0, a1, a2,
                      logic [7:0] b0, b1, b2,
                      logic last);
    in_a = {a2, a1, a0};
    in_b = {b2, b1, b0};
    in_last = last;
    in_valid = 1;
    @(negedge clk);
    chk("in_ready_s", in_ready_s, 1);
    chk("in_ready_w", in_ready_w, 1);
    @(posedge clk); #1;
    in_valid = 0;
    in_last = 0;
    in_a = '0;
    in_b = '0;
  endtask

  task automatic bubble(int n);
    in_valid = 0;
    in_last = 1;
    in_a = 24'hFFFFFF;
    in_b = 24'hFFFFFF;
    repeat (n) begin
      @(posedge clk); #1;
    end
    in_last = 0;
    in_a = '0;
    in_b = '0;
  endtask

  task automatic wait_valid(int lat);
    int n;
    chk("flush_in_ready", in_ready_s, 0);
    chk("flush_busy", busy_s, 1);
    chk("flush_valid", out_valid_s, 0);
    n = 0;
    while (!out_valid_s && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, lat);
    chk("valid_w", out_valid_w, out_valid_s);
  endtask

  task automatic drain(int stall_row, int stall_cyc);
    logic [71:0] er_s;
    logic [47:0] er_w;
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 3; j++) begin
        er_s[j*24 +: 24] = exp_s[r*3+j];
        er_w[j*16 +: 16] = exp_w[r*3+j];
      end
      if (r == stall_row) begin
        out_ready = 0;
        repeat (stall_cyc) begin
          @(posedge clk); #1;
          chk("stall_valid", out_valid_s, 1);
          chk("stall_idx", idx_s, r);
          chk("stall_row", out_row_s, er_s);
          chk("stall_last", out_last_s, 0);
        end
        out_ready = 1;
      end
      chk("valid_s", out_valid_s, 1);
      chk("valid_w", out_valid_w, 1);
      chk("idx_s", idx_s, r);
      chk("idx_w", idx_w, r);
      chk("last_s", out_last_s, (r == 2));
      chk("last_w", out_last_w, (r == 2));
      chk("drain_in_ready", in_ready_s, 0);
      chk("row_s", out_row_s, er_s);
      chk("row_w", out_row_w, er_w);
      @(posedge clk); #1;
    end
    chk("done_valid", out_valid_s, 0);
    chk("done_busy", busy_s, 0);
    chk("done_in_ready", in_ready_s, 1);
    chk("done_busy_w", busy_w, 0);
  endtask

  task automatic job_3x3();
    beat(1, 4, 7, 1, 2, 3, 0);
    beat(2, 5, 8, 4, 5, 6, 0);
    beat(3, 6, 9, 7, 8, 9, 1);
  endtask

  initial begin
    exp_s = '{24'd30, 24'd36, 24'd42,
              24'd66, 24'd81, 24'd96,
              24'd102, 24'd126, 24'd150};
    exp_w = '{16'd30, 16'd36, 16'd42,
              16'd66, 16'd81, 16'd96,
              16'd102, 16'd126, 16'd150};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready_s, 0);
    chk("rst_in_ready_w", in_ready_w, 0);
    chk("rst_valid", out_valid_s, 0);
    chk("rst_busy", busy_s, 0);
    chk("rst_row", out_row_s, 0);
    chk("rst_idx", idx_s, 0);
    chk("rst_last", out_last_s, 0);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready_s, 1);

    job_3x3();
    wait_valid(6);
    drain(-1, 0);

    beat(1, 4, 7, 1, 2, 3, 0);
    bubble(2);
    beat(2, 5, 8, 4, 5, 6, 0);
    beat(3, 6, 9, 7, 8, 9, 1);
    wait_valid(6);
    drain(1, 5);

    for (int i = 0; i < 9; i++) begin
      exp_s[i] = 24'hFFFFF8;
      exp_w[i] = 16'd2040;
    end
    repeat (3) beat(8'hFF, 8'hFF, 8'hFF, 2, 2, 2, 0);
    beat(8'hFF, 8'hFF, 8'hFF, 2, 2, 2, 1);
    wait_valid(6);
    drain(-1, 0);

    for (int i = 0; i < 9; i++) begin
      exp_s[i] = 24'd2;
      exp_w[i] = 16'd64514;
    end
    beat(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);
    beat(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1);
    wait_valid(6);
    drain(-1, 0);

    beat(9, 9, 9, 9, 9, 9, 0);
    beat(7, 7, 7, 7, 7, 7, 0);
    reset = 0;
    @(negedge clk);
    chk("abort_in_ready", in_ready_s, 0);
    chk("abort_busy", busy_s, 0);
    chk("abort_valid", out_valid_s, 0);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 3; j++) begin
        exp_s[r*3+j] = 24'(r + 1);
        exp_w[r*3+j] = 16'(r + 1);
      end
    beat(1, 2, 3, 1, 1, 1, 1);
    wait_valid(6);
    drain(-1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
